// File: rtl/driver_sout_readback.sv
// SOUT readback checker: scans each driver through the SOUT mux, deserializes its 48-bit word and compares it with expected_conf.
// Optional input synchronizers are enabled by defining DRIVER_READBACK_SYNC_EN.
module driver_sout_readback #(
  parameter int N_DRIVERS = 30,
  parameter int CONF_W    = 48,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 shift_start,
  input  logic                 driver_sclk,
  input  logic                 driver_lat,
  input  logic                 driver_sout,
  input  logic [CONF_W-1:0]    expected_conf,
  output logic [4:0]           sout_mux,
  output logic                 busy,
  output logic                 done,
  output logic [N_DRIVERS-1:0] error_mask,
  output logic                 short_frame,
  output logic [CONF_W-1:0]    captured_conf,
  output logic                 captured_valid
);

  localparam int CW = $clog2(CONF_W + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [4:0]    LAST_DRV = 5'(N_DRIVERS - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CONF_W - 1);
  localparam logic [SW-1:0] LAST_SET = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_SHIFT, S_CAPTURE, S_CHECK
  } state_t;

  logic sclk_in, sout_in, shift_in, lat_in;

`ifdef DRIVER_READBACK_SYNC_EN
  // sclk/sout are synchronized; shift_start/lat take an equal 2-cycle delay to stay aligned.
  logic [1:0] sclk_s, sout_s, shift_s, lat_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s  <= '0;
      sout_s  <= '0;
      shift_s <= '0;
      lat_s   <= '0;
    end else begin
      sclk_s  <= {sclk_s[0], driver_sclk};
      sout_s  <= {sout_s[0], driver_sout};
      shift_s <= {shift_s[0], shift_start};
      lat_s   <= {lat_s[0], driver_lat};
    end
  end

  assign sclk_in  = sclk_s[1];
  assign sout_in  = sout_s[1];
  assign shift_in = shift_s[1];
  assign lat_in   = lat_s[1];
`else
  assign sclk_in  = driver_sclk;
  assign sout_in  = driver_sout;
  assign shift_in = shift_start;
  assign lat_in   = driver_lat;
`endif

  state_t            state;
  logic              sclk_q, lat_q;
  logic [CW-1:0]     bit_cnt;
  logic [SW-1:0]     settle_cnt;
  logic [CONF_W-1:0] shreg;
  logic              sclk_rise, lat_rise, step;
  logic [CONF_W-1:0] next_word;

  assign sclk_rise = sclk_in & ~sclk_q;
  assign lat_rise  = lat_in & ~lat_q;
  assign next_word = {shreg[CONF_W-2:0], sout_in};
  // Next-driver step: after CHECK, or on a latch that cuts a capture short.
  assign step = (state == S_CHECK) ||
                ((state == S_CAPTURE) && !sclk_rise && lat_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      sclk_q         <= 1'b0;
      lat_q          <= 1'b0;
      bit_cnt        <= '0;
      settle_cnt     <= '0;
      shreg          <= '0;
      sout_mux       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error_mask     <= '0;
      short_frame    <= 1'b0;
      captured_conf  <= '0;
      captured_valid <= 1'b0;
    end else begin
      sclk_q         <= sclk_in;
      lat_q          <= lat_in;
      done           <= 1'b0;
      captured_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            error_mask  <= '0;
            short_frame <= 1'b0;
            sout_mux    <= '0;
            busy        <= 1'b1;
            settle_cnt  <= '0;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == LAST_SET) state <= S_WAIT_SHIFT;
          else                        settle_cnt <= settle_cnt + 1'b1;
        end
        S_WAIT_SHIFT: begin
          if (shift_in) begin
            bit_cnt <= '0;
            shreg   <= '0;
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sclk_rise) begin
            shreg   <= next_word;
            bit_cnt <= bit_cnt + 1'b1;
            // Result is published on the last edge so it is visible during CHECK.
            if (bit_cnt == LAST_BIT) begin
              captured_conf  <= next_word;
              captured_valid <= 1'b1;
              if (next_word != expected_conf) error_mask[sout_mux] <= 1'b1;
              state <= S_CHECK;
            end
          end else if (lat_rise) begin
            error_mask[sout_mux] <= 1'b1;
            short_frame          <= 1'b1;
          end
        end
        default: ;
      endcase
      if (step) begin
        if (sout_mux == LAST_DRV) begin
          done     <= 1'b1;
          busy     <= 1'b0;
          sout_mux <= '0;
          state    <= S_IDLE;
        end else begin
          sout_mux   <= sout_mux + 1'b1;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_driver_sout_readback.sv
// Scoreboard bench for driver_sout_readback: a driver-chain model issues shifts, a monitor checks captures and scan results.
module tb_driver_sout_readback;
  localparam int N  = 30;
  localparam int W  = 48;
  localparam int ST = 2;
`ifdef DRIVER_READBACK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, shift_start = 1'b0;
  logic driver_sclk = 1'b0, driver_lat = 1'b0, driver_sout = 1'b0;
  logic [W-1:0] expected_conf = '0;
  logic [4:0]   sout_mux;
  logic         busy, done, short_frame, captured_valid;
  logic [N-1:0] error_mask;
  logic [W-1:0] captured_conf;

  driver_sout_readback #(.N_DRIVERS(N), .CONF_W(W), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .shift_start(shift_start),
    .driver_sclk(driver_sclk), .driver_lat(driver_lat), .driver_sout(driver_sout),
    .expected_conf(expected_conf), .sout_mux(sout_mux), .busy(busy), .done(done),
    .error_mask(error_mask), .short_frame(short_frame),
    .captured_conf(captured_conf), .captured_valid(captured_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int last_edge = 0;

  logic [W-1:0] cap_q[$];
  int           idx_q[$];
  logic [N-1:0] mask_q[$];
  bit           sf_q[$];

  logic [W-1:0] words[N];
  int           edges[N];
  bit           guard_at[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a capture or a scan completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (captured_valid) begin
        if (cap_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_capture: got %0h expected none", captured_conf);
        end else begin
          check("captured_conf", 64'(captured_conf), 64'(cap_q.pop_front()));
          check("capture_mux", 64'(sout_mux), 64'(idx_q.pop_front()));
          check("capture_latency", 64'(cyc - last_edge), 64'(1 + LAT));
        end
      end
      if (done) begin
        check("done_busy_overlap", 64'(busy), 64'(0));
        check("done_mux", 64'(sout_mux), 64'(0));
        if (mask_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          check("error_mask", 64'(error_mask), 64'(mask_q.pop_front()));
          check("short_frame", 64'(short_frame), 64'(sf_q.pop_front()));
        end
      end
    end
  end

  task automatic shift(input logic [W-1:0] word, input int nedges, input bit guard);
    @(negedge clk) shift_start = 1'b1;
    for (int i = 0; i < nedges; i++) begin
      @(negedge clk);
      shift_start = 1'b0;
      driver_sclk = 1'b1;
      driver_sout = word[W-1-i];
      last_edge   = cyc;
      @(negedge clk);
      driver_sclk = 1'b0;
      driver_sout = 1'($urandom);
    end
    shift_start = 1'b0;
    @(negedge clk) driver_lat = 1'b1;
    @(negedge clk) driver_lat = 1'b0;
    if (guard) begin
      // One cycle after the mux moves: must be ignored, so this all-ones burst must never be captured.
      shift_start = 1'b1;
      @(negedge clk) shift_start = 1'b0;
      for (int i = 0; i < W; i++) begin
        driver_sclk = 1'b1; driver_sout = 1'b1;
        @(negedge clk) driver_sclk = 1'b0;
        @(negedge clk);
      end
      driver_lat = 1'b1;
      @(negedge clk) driver_lat = 1'b0;
    end
    repeat (3 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  // Reference: a full frame reproduces the driver word; a short frame or differing word flags the driver.
  task automatic run_scan(input int stop_at);
    logic [N-1:0] m = '0;
    bit sf = 1'b0;
    for (int d = 0; d < N; d++) begin
      if (stop_at >= 0 && d >= stop_at) break;
      if (edges[d] == W) begin
        cap_q.push_back(words[d]);
        idx_q.push_back(d);
        if (words[d] != expected_conf) m[d] = 1'b1;
      end else begin
        m[d] = 1'b1;
        sf   = 1'b1;
      end
    end
    if (stop_at < 0) begin
      mask_q.push_back(m);
      sf_q.push_back(sf);
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (ST + 1) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      if (d == stop_at) begin
        @(negedge clk) shift_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          shift_start = 1'b0;
          driver_sclk = 1'b1;
          driver_sout = 1'($urandom);
          @(negedge clk) driver_sclk = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_mux", 64'(sout_mux), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_mask", 64'(error_mask), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        return;
      end
      shift(words[d], edges[d], guard_at[d]);
    end
  endtask

  task automatic fill(input logic [W-1:0] exp, input bit randomize_it);
    expected_conf = exp;
    for (int d = 0; d < N; d++) begin
      words[d]    = exp;
      edges[d]    = W;
      guard_at[d] = 1'b0;
      if (randomize_it) begin
        if ($urandom_range(0, 3) == 0) words[d] = {$urandom, $urandom} ^ {W{1'b0}};
        if ($urandom_range(0, 9) == 0) edges[d] = $urandom_range(1, W - 1);
        if (d > 0 && d < N - 1 && edges[d] == W && $urandom_range(0, 4) == 0) guard_at[d] = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mux", 64'(sout_mux), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_mask", 64'(error_mask), 64'(0));
    check("rst_short", 64'(short_frame), 64'(0));
    check("rst_conf", 64'(captured_conf), 64'(0));
    check("rst_valid", 64'(captured_valid), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill(48'hA5A5_1234_5678, 1'b0);
    run_scan(-1);

    fill(48'hA5A5_1234_5678, 1'b0);
    words[7]     = 48'hA5A5_1234_5679;
    edges[3]     = 20;
    guard_at[10] = 1'b1;
    run_scan(-1);

    fill({$urandom, $urandom} ^ {W{1'b0}}, 1'b1);
    words[0] = 48'h8000_0000_0000;
    edges[0] = W;
    run_scan(-1);

    fill(48'hA5A5_1234_5678, 1'b0);
    run_scan(5);

    fill({$urandom, $urandom} ^ {W{1'b0}}, 1'b1);
    run_scan(-1);

    for (int i = 0; i < 200 && (cap_q.size() != 0 || mask_q.size() != 0); i++) @(negedge clk);
    check("capture_queue_drained", 64'(cap_q.size()), 64'(0));
    check("scan_queue_drained", 64'(mask_q.size()), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/driver_sout_readback.md
# driver_sout_readback

Readback checker for the LED driver daisy configuration path. On each configuration shift issued by the driver controller, every driver shifts its previously stored 48-bit configuration out on SOUT. This block selects one driver at a time through the SOUT mux, deserializes that driver's SOUT stream, and compares it against the expected configuration. It sits beside the driver controller, observing its sclk/lat outputs and driving the SOUT mux select.

## Interface

Parameters:
- N_DRIVERS, 30, number of drivers scanned (1..32)
- CONF_W, 48, configuration word width in bits
- SETTLE, 2, clk cycles the mux select must be stable before a capture may arm (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a scan of all drivers
- shift_start  in  1  one-cycle pulse from the controller, one cycle before the first sclk rising edge of a configuration shift
- driver_sclk  in  1  controller sclk, generated in the clk domain
- driver_lat  in  1  controller latch
- driver_sout  in  1  muxed SOUT from the selected driver
- expected_conf  in  CONF_W  configuration currently held in the drivers
- sout_mux  out  5  driver select for the SOUT mux
- busy  out  1  high from the accepted start through the final check
- done  out  1  one-cycle pulse at scan completion
- error_mask  out  N_DRIVERS  bit i set when driver i mismatched or was short-framed
- short_frame  out  1  sticky; a latch arrived before CONF_W edges
- captured_conf  out  CONF_W  last word captured
- captured_valid  out  1  one-cycle pulse when captured_conf updates

## Operation

- States: IDLE, SETTLE, WAIT_SHIFT, CAPTURE, CHECK.
- IDLE: a start pulse clears error_mask and short_frame, sets sout_mux=0 and busy=1, and enters SETTLE. start is ignored in every other state.
- SETTLE: counts SETTLE cycles with sout_mux stable, then enters WAIT_SHIFT. A shift_start pulse in SETTLE is ignored and the block waits for the next shift.
- WAIT_SHIFT: shift_start moves to CAPTURE and clears the bit counter and shift register.
- CAPTURE:
  - Rising edge of driver_sclk: sclk_q==0 and driver_sclk==1, where sclk_q is driver_sclk registered once.
  - On each rising edge, driver_sout is sampled in that same cycle and shifted in MSB-first. The first bit lands in bit CONF_W-1.
  - After CONF_W edges, the block enters CHECK. Further sclk edges are ignored.
  - If driver_lat rises before CONF_W edges, the capture aborts: set error_mask[sout_mux], set short_frame, and go to the next-driver step without a CHECK.
- CHECK, one cycle:
  - captured_conf = shift register; pulse captured_valid.
  - If shift register != expected_conf (sampled this cycle), set error_mask[sout_mux].
- Next-driver step, taken from CHECK or after an abort:
  - If sout_mux == N_DRIVERS-1: pulse done, clear busy, set sout_mux=0, go to IDLE.
  - Otherwise, increment sout_mux and go to SETTLE.
- error_mask and captured_conf hold their values after done until the next start.
- The counter is $clog2(CONF_W+1) bits. sout_mux never exceeds N_DRIVERS-1.

## Timing

- Reset values:
  - sout_mux=0, busy=0, done=0, error_mask=0, short_frame=0, captured_conf=0, captured_valid=0.
  - State IDLE; counters and shift register 0.
- rst asserted mid-scan returns the block to reset values immediately. No done pulse is emitted.
- Per driver, from the CONF_W-th sclk edge:
  - CHECK, captured_valid, and error_mask update occur 1 cycle later.
  - The new sout_mux appears 2 cycles later.
- Minimum inter-driver gap is SETTLE+1 cycles before a shift_start can be accepted.
- done is asserted in the cycle after the last CHECK (or abort) and is never asserted together with busy.
- Simultaneous shift_start and start in IDLE: start wins; the shift is not captured because SETTLE has not elapsed.
- A full scan needs N_DRIVERS configuration shifts.

## Configuration

- DRIVER_READBACK_SYNC_EN defined:
  - driver_sout and driver_sclk each pass through a 2-flop synchronizer before edge detection and sampling, keeping them aligned.
  - shift_start and driver_lat are delayed by 2 cycles to match.
  - All capture and check events occur 2 cycles later than listed above.
- Undefined: inputs are used directly, with the timing listed above.

## Test plan

- Reset: all outputs 0 after rst; a scan with rst pulsed at driver 5 leaves sout_mux=0, busy=0, and no done.
- Clean scan, N_DRIVERS=30: every driver returns 48'hA5A5_1234_5678 == expected_conf -> 30 captured_valid pulses, sout_mux steps 0..29, done once, error_mask=0.
- Single mismatch: driver 7 returns expected_conf with bit 0 flipped -> error_mask=30'h80 and captured_conf shows the flipped word.
- Short frame: driver 3 receives 20 sclk edges then lat -> error_mask[3]=1, short_frame=1, scan continues to driver 4.
- Settle guard with SETTLE=2: shift_start one cycle after a mux change -> no capture; the next shift_start is captured normally.
- Bit ordering: SOUT stream 1 followed by 47 zeros -> captured_conf=48'h8000_0000_0000; repeated with DRIVER_READBACK_SYNC_EN, captured_valid arrives 2 cycles later.
